hazard_scheduler: RTL and testbench

//  Central hazard/stall scheduler for the 5-stage static pipeline (IF/ID/EXE/MEM/WB).
//  - Tracks in-flight register writes in a 3-entry scoreboard (EXE, MEM, WB).
//  - Detects RAW hazards for the instruction in ID; drives stall, bubble and forwarding selects.
//  - Sequences the multi-cycle MUL/DIV unit and blocks HI/LO consumers until it completes.
//  - Sits beside InstDecode and replaces its ad-hoc stall logic.

---
 rtl/hazard_scheduler_pkg.sv | 30 +++
 rtl/hazard_scheduler_if.sv | 42 ++++
 rtl/hazard_scheduler_muldiv.sv | 66 ++++++
 rtl/hazard_scheduler.sv | 103 ++++++++++
 tb/tb_hazard_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Shared pipeline-control types: forward selects, scoreboard entry, MUL/DIV FSM states.
// Pure declarations; no latency or backpressure of its own.
package pipe_ctrl_pkg;

  localparam int SB_ADDR_W = 5;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_EXE  = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_WB   = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic                 is_load;
  } sb_entry_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // $0 is hard-wired, so it never creates a dependency.
  function automatic logic src_match(input logic used,
                                     input logic [SB_ADDR_W-1:0] src,
                                     input sb_entry_t e);
    return used && (src != '0) && e.valid && (e.addr == src);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage request bundle into the hazard scheduler and its stall/forward/MUL-DIV responses.
// Wires only; timing is owned by the scheduler.
interface hazard_scheduler_if #(
  parameter int REG_ADDR_W = 5
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic                  id_rs_used;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic                  id_rt_used;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_rd_wen;
  logic                  id_is_load;
  logic                  id_is_muldiv;
  logic                  id_is_div;
  logic                  id_uses_hilo;

  logic                  stall;
  logic                  bubble;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  muldiv_start;
  logic                  muldiv_is_div;
  logic                  muldiv_busy;
  logic                  muldiv_done;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
           id_rd_addr, id_rd_wen, id_is_load, id_is_muldiv, id_is_div, id_uses_hilo,
    input  stall, bubble, fwd_a_sel, fwd_b_sel,
           muldiv_start, muldiv_is_div, muldiv_busy, muldiv_done
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
           id_rd_addr, id_rd_wen, id_is_load, id_is_muldiv, id_is_div, id_uses_hilo,
    output stall, bubble, fwd_a_sel, fwd_b_sel,
           muldiv_start, muldiv_is_div, muldiv_busy, muldiv_done
  );

endinterface

// File: rtl/hazard_scheduler_muldiv.sv
// MUL/DIV occupancy sequencer: start pulse same cycle as request, busy for exactly N cycles after it.
// Latency: start combinational, state on negedge; a request is ignored while hold is high or unit is busy.
module muldiv_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic req_is_div,
  input  logic hold,
  output logic start,
  output logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(negedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    is_div    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (req && !hold && !reset) begin
          start     = 1'b1;
          is_div    = req_is_div;
          cnt_nxt   = req_is_div ? DIV_LOAD : MUL_LOAD;
          state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          state_nxt = MD_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Held in reset, nothing is reported busy, so an aborted op never signals done.
  assign busy = (state == MD_BUSY) && !reset;
  assign done = busy && (cnt == '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: EXE/MEM/WB write scoreboard, RAW + HI/LO interlock, MUL/DIV sequencing.
// Outputs combinational, state on negedge; stall/bubble hold IF/ID. HAZARD_FWD_EN enables forwarding.
module hazard_scheduler
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic               clk,
  input logic               reset,
  hazard_scheduler_if.slave bus
);

  sb_entry_t sb_exe, sb_mem, sb_wb;

  logic [REG_ADDR_W-1:0] rs_addr, rt_addr;
  logic a_exe, a_mem, a_wb;
  logic b_exe, b_mem, b_wb;
  logic raw_stall, hilo_stall, stall_int;
  logic [1:0] fwd_a, fwd_b;
  logic md_busy;
  logic sb_unused;

  assign rs_addr = bus.id_rs_addr;
  assign rt_addr = bus.id_rt_addr;

  always_ff @(negedge clk) begin
    if (reset) begin
      sb_exe <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      if (bus.id_valid && bus.id_rd_wen && (bus.id_rd_addr != '0) && !stall_int) begin
        sb_exe <= '{valid: 1'b1, addr: bus.id_rd_addr, is_load: bus.id_is_load};
      end else begin
        sb_exe <= '0;
      end
      sb_mem <= sb_exe;
      sb_wb  <= sb_mem;
    end
  end

  // WB retires, so its load flag never influences a decision.
  assign sb_unused = sb_wb.is_load;

  assign a_exe = src_match(bus.id_rs_used, rs_addr, sb_exe);
  assign a_mem = src_match(bus.id_rs_used, rs_addr, sb_mem);
  assign a_wb  = src_match(bus.id_rs_used, rs_addr, sb_wb);
  assign b_exe = src_match(bus.id_rt_used, rt_addr, sb_exe);
  assign b_mem = src_match(bus.id_rt_used, rt_addr, sb_mem);
  assign b_wb  = src_match(bus.id_rt_used, rt_addr, sb_wb);

`ifdef HAZARD_FWD_EN
  // Nearest producer wins; a load still in EXE has no data yet and forces one bubble.
  always_comb begin
    fwd_a = FWD_NONE;
    if (a_exe)      fwd_a = sb_exe.is_load ? FWD_NONE : FWD_EXE;
    else if (a_mem) fwd_a = FWD_MEM;
    else if (a_wb)  fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_NONE;
    if (b_exe)      fwd_b = sb_exe.is_load ? FWD_NONE : FWD_EXE;
    else if (b_mem) fwd_b = FWD_MEM;
    else if (b_wb)  fwd_b = FWD_WB;
  end

  assign raw_stall = bus.id_valid && sb_exe.is_load && (a_exe || b_exe);
`else
  assign fwd_a     = FWD_NONE;
  assign fwd_b     = FWD_NONE;
  assign raw_stall = bus.id_valid && (a_exe || a_mem || a_wb || b_exe || b_mem || b_wb);
`endif

  assign hilo_stall = bus.id_valid && (bus.id_uses_hilo || bus.id_is_muldiv) && md_busy;
  assign stall_int  = !reset && (raw_stall || hilo_stall);

  muldiv_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.id_valid && bus.id_is_muldiv),
    .req_is_div (bus.id_is_div),
    .hold       (stall_int),
    .start      (bus.muldiv_start),
    .is_div     (bus.muldiv_is_div),
    .busy       (md_busy),
    .done       (bus.muldiv_done)
  );

  assign bus.muldiv_busy = md_busy;
  assign bus.stall       = stall_int;
  assign bus.bubble      = stall_int;
  assign bus.fwd_a_sel   = (bus.id_valid && !reset) ? fwd_a : FWD_NONE;
  assign bus.fwd_b_sel   = (bus.id_valid && !reset) ? fwd_b : FWD_NONE;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed vector table, multi-cycle MUL/DIV/reset sequences, then random traffic against a history model.
module tb_hazard_scheduler;
  import pipe_ctrl_pkg::*;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scheduler_if bus ();

  hazard_scheduler #(
    .REG_ADDR_W (5),
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit wen, input bit ld, input bit md, input bit dv,
                        input bit hl);
    bus.id_valid     = v;
    bus.id_rs_addr   = 5'(rs);
    bus.id_rs_used   = rsu;
    bus.id_rt_addr   = 5'(rt);
    bus.id_rt_used   = rtu;
    bus.id_rd_addr   = 5'(rd);
    bus.id_rd_wen    = wen;
    bus.id_is_load   = ld;
    bus.id_is_muldiv = md;
    bus.id_is_div    = dv;
    bus.id_uses_hilo = hl;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"},  32'(bus.stall), 0);
    chk({tag, " bubble"}, 32'(bus.bubble), 0);
    chk({tag, " fwd_a"},  32'(bus.fwd_a_sel), 0);
    chk({tag, " fwd_b"},  32'(bus.fwd_b_sel), 0);
    chk({tag, " start"},  32'(bus.muldiv_start), 0);
    chk({tag, " is_div"}, 32'(bus.muldiv_is_div), 0);
    chk({tag, " busy"},   32'(bus.muldiv_busy), 0);
    chk({tag, " done"},   32'(bus.muldiv_done), 0);
  endtask

  typedef struct {
    bit       v;
    int       rs;
    bit       rsu;
    int       rt;
    bit       rtu;
    int       rd;
    bit       wen;
    bit       ld;
    bit       e_stall;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit wen, bit ld,
                              bit st, logic [1:0] fa, logic [1:0] fb);
    vec_t x;
    x = '{v, rs, rsu, rt, rtu, rd, wen, ld, st, fa, fb};
    return x;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
  endtask

  // Reference model: what each in-flight instruction wrote, 1/2/3 edges ago, plus cycles left on MUL/DIV.
  typedef struct { bit v; int addr; bit ld; } hist_t;
  hist_t hist[3];
  int    md_rem;

  task automatic model_eval(input bit rst, input bit v, input int rs, input bit rsu, input int rt,
                            input bit rtu, input bit md, input bit dv, input bit hl,
                            output bit st, output logic [1:0] fa, output logic [1:0] fb,
                            output bit start, output bit isdiv, output bit busy, output bit done);
    int ka, kb;
    bit lu;
    logic [1:0] sel_of[3];
    sel_of[0] = FWD_EXE; sel_of[1] = FWD_MEM; sel_of[2] = FWD_WB;
    ka = -1; kb = -1;
    for (int k = 2; k >= 0; k--) begin
      if (rsu && rs != 0 && hist[k].v && hist[k].addr == rs) ka = k;
      if (rtu && rt != 0 && hist[k].v && hist[k].addr == rt) kb = k;
    end
    fa = FWD_NONE; fb = FWD_NONE;
    if (FWD) begin
      lu = (ka == 0 && hist[0].ld) || (kb == 0 && hist[0].ld);
      if (ka >= 0 && !(ka == 0 && hist[0].ld)) fa = sel_of[ka];
      if (kb >= 0 && !(kb == 0 && hist[0].ld)) fb = sel_of[kb];
      st = v && lu;
    end else begin
      st = v && (ka >= 0 || kb >= 0);
    end
    busy  = md_rem > 0;
    done  = md_rem == 1;
    st    = st || (v && (hl || md) && busy);
    start = v && md && !st && !busy;
    isdiv = start && dv;
    if (rst) begin
      st = 0; fa = FWD_NONE; fb = FWD_NONE; start = 0; isdiv = 0; busy = 0; done = 0;
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input int rd, input bit wen, input bit ld,
                            input bit st, input bit start, input bit dv);
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
      md_rem = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (v && wen && rd != 0 && !st) ? '{1, rd, ld} : '{0, 0, 0};
      if (start) md_rem = dv ? DIV_N : MUL_N;
      else if (md_rem > 0) md_rem--;
    end
  endtask

  initial begin
    int stalls, busy_n, done_at, ndone, starts, gap;
    bit released;

    // Reset state
    reset = 1'b1;
    idle_in();
    @(negedge clk); #1;
    @(posedge clk);
    chk_all_zero("reset");
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    chk_all_zero("post_reset");
    @(negedge clk); #1;

    // addi $1,$0,5 ; add $2,$1,$1
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0, FWD_NONE, FWD_NONE));
    if (FWD) vecs.push_back(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, FWD_EXE, FWD_EXE));
    else begin
      repeat (3) vecs.push_back(mk(1, 1, 1, 1, 1, 2, 1, 0, 1, FWD_NONE, FWD_NONE));
      vecs.push_back(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, FWD_NONE, FWD_NONE));
    end
    push_idle(3);
    // lw $3,0($0) ; addu $4,$3,$3
    vecs.push_back(mk(1, 0, 1, 0, 0, 3, 1, 1, 0, FWD_NONE, FWD_NONE));
    if (FWD) begin
      vecs.push_back(mk(1, 3, 1, 3, 1, 4, 1, 0, 1, FWD_NONE, FWD_NONE));
      vecs.push_back(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, FWD_MEM, FWD_MEM));
    end else begin
      repeat (3) vecs.push_back(mk(1, 3, 1, 3, 1, 4, 1, 0, 1, FWD_NONE, FWD_NONE));
      vecs.push_back(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, FWD_NONE, FWD_NONE));
    end
    push_idle(3);
    // addi $0,$0,7 ; or $5,$0,$0
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, FWD_NONE, FWD_NONE));
    vecs.push_back(mk(1, 0, 1, 0, 1, 5, 1, 0, 0, FWD_NONE, FWD_NONE));
    push_idle(3);
    // addi $9 ; nop ; nop ; sub $10,$0,$9  (producer in WB)
    vecs.push_back(mk(1, 0, 1, 0, 0, 9, 1, 0, 0, FWD_NONE, FWD_NONE));
    push_idle(2);
    if (FWD) vecs.push_back(mk(1, 0, 1, 9, 1, 10, 1, 0, 0, FWD_NONE, FWD_WB));
    else begin
      vecs.push_back(mk(1, 0, 1, 9, 1, 10, 1, 0, 1, FWD_NONE, FWD_NONE));
      vecs.push_back(mk(1, 0, 1, 9, 1, 10, 1, 0, 0, FWD_NONE, FWD_NONE));
    end
    push_idle(3);
    // addi $11 ; invalid slot reading $11 ; instruction naming $11 without reading it
    vecs.push_back(mk(1, 0, 1, 0, 0, 11, 1, 0, 0, FWD_NONE, FWD_NONE));
    vecs.push_back(mk(0, 11, 1, 11, 1, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    vecs.push_back(mk(1, 11, 0, 11, 0, 12, 1, 0, 0, FWD_NONE, FWD_NONE));
    push_idle(3);
    // lw $13 ; nop ; add $14,$13,$0  (load already in MEM)
    vecs.push_back(mk(1, 0, 1, 0, 0, 13, 1, 1, 0, FWD_NONE, FWD_NONE));
    push_idle(1);
    if (FWD) vecs.push_back(mk(1, 13, 1, 0, 1, 14, 1, 0, 0, FWD_MEM, FWD_NONE));
    else begin
      repeat (2) vecs.push_back(mk(1, 13, 1, 0, 1, 14, 1, 0, 1, FWD_NONE, FWD_NONE));
      vecs.push_back(mk(1, 13, 1, 0, 1, 14, 1, 0, 0, FWD_NONE, FWD_NONE));
    end
    push_idle(3);
    // addi $15 ; addi $15 ; add $16,$15,$0  (nearest producer wins)
    vecs.push_back(mk(1, 0, 1, 0, 0, 15, 1, 0, 0, FWD_NONE, FWD_NONE));
    vecs.push_back(mk(1, 0, 1, 0, 0, 15, 1, 0, 0, FWD_NONE, FWD_NONE));
    if (FWD) vecs.push_back(mk(1, 15, 1, 0, 1, 16, 1, 0, 0, FWD_EXE, FWD_NONE));
    else begin
      repeat (3) vecs.push_back(mk(1, 15, 1, 0, 1, 16, 1, 0, 1, FWD_NONE, FWD_NONE));
      vecs.push_back(mk(1, 15, 1, 0, 1, 16, 1, 0, 0, FWD_NONE, FWD_NONE));
    end
    push_idle(3);

    foreach (vecs[i]) begin
      set_in(vecs[i].v, vecs[i].rs, vecs[i].rsu, vecs[i].rt, vecs[i].rtu, vecs[i].rd,
             vecs[i].wen, vecs[i].ld, 0, 0, 0);
      @(posedge clk);
      chk($sformatf("vec%0d stall", i),  32'(bus.stall),     32'(vecs[i].e_stall));
      chk($sformatf("vec%0d bubble", i), 32'(bus.bubble),    32'(vecs[i].e_stall));
      chk($sformatf("vec%0d fwd_a", i),  32'(bus.fwd_a_sel), 32'(vecs[i].e_fa));
      chk($sformatf("vec%0d fwd_b", i),  32'(bus.fwd_b_sel), 32'(vecs[i].e_fb));
      @(negedge clk); #1;
    end

    // div $6,$7 ; mflo $8
    do_reset();
    set_in(1, 6, 1, 7, 1, 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    chk("div start", 32'(bus.muldiv_start), 1);
    chk("div is_div", 32'(bus.muldiv_is_div), 1);
    chk("div busy_at_start", 32'(bus.muldiv_busy), 0);
    @(negedge clk); #1;
    set_in(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1);
    stalls = 0; busy_n = 0; done_at = -1; ndone = 0; starts = 0; released = 0;
    for (int c = 0; c < 40 && !released; c++) begin
      @(posedge clk);
      if (bus.muldiv_busy) busy_n++;
      if (bus.muldiv_done) begin ndone++; done_at = busy_n; end
      if (bus.muldiv_start) starts++;
      if (bus.stall) stalls++; else released = 1;
      @(negedge clk); #1;
    end
    chk("mflo released", 32'(released), 1);
    chk("mflo stall_cycles", 32'(stalls), DIV_N);
    chk("div busy_cycles", 32'(busy_n), DIV_N);
    chk("div done_cycle", 32'(done_at), DIV_N);
    chk("div done_pulses", 32'(ndone), 1);
    chk("div extra_starts", 32'(starts), 0);

    // mult $1,$2 ; mult $3,$4
    do_reset();
    set_in(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    chk("mult1 start", 32'(bus.muldiv_start), 1);
    chk("mult1 is_div", 32'(bus.muldiv_is_div), 0);
    @(negedge clk); #1;
    set_in(1, 3, 1, 4, 1, 0, 0, 0, 1, 0, 0);
    gap = -1;
    for (int c = 1; c <= 20 && gap < 0; c++) begin
      @(posedge clk);
      if (bus.muldiv_start) begin
        gap = c;
        chk("mult2 is_div", 32'(bus.muldiv_is_div), 0);
        chk("mult2 stall", 32'(bus.stall), 0);
      end
      @(negedge clk); #1;
    end
    chk("mult2 start_gap", 32'(gap), MUL_N + 1);

    // reset at busy cycle 10 of a div
    do_reset();
    set_in(1, 6, 1, 7, 1, 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    chk("div2 start", 32'(bus.muldiv_start), 1);
    @(negedge clk); #1;
    idle_in();
    repeat (9) begin @(posedge clk); @(negedge clk); #1; end
    @(posedge clk);
    chk("div2 busy_c10", 32'(bus.muldiv_busy), 1);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    chk_all_zero("abort");
    busy_n = 0; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      @(posedge clk);
      if (bus.muldiv_busy) busy_n++;
      if (bus.muldiv_done) ndone++;
    end
    chk("abort busy_after", 32'(busy_n), 0);
    chk("abort done_after", 32'(ndone), 0);
    @(negedge clk); #1;

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
    md_rem = 0;
    begin
      bit v, rsu, rtu, wen, ld, md, dv, hl, rst, prev_st;
      int rs, rt, rd;
      bit e_st, e_start, e_isdiv, e_busy, e_done;
      logic [1:0] e_fa, e_fb;
      prev_st = 0;
      v = 0; rs = 0; rsu = 0; rt = 0; rtu = 0; rd = 0; wen = 0; ld = 0; md = 0; dv = 0; hl = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (!(prev_st && $urandom_range(0, 1) == 1)) begin
          v   = $urandom_range(0, 7) != 0;
          rs  = $urandom_range(0, 3);
          rsu = $urandom_range(0, 3) != 0;
          rt  = $urandom_range(0, 3);
          rtu = $urandom_range(0, 1) == 1;
          rd  = $urandom_range(0, 3);
          wen = $urandom_range(0, 3) != 0;
          ld  = $urandom_range(0, 3) == 0;
          md  = $urandom_range(0, 7) == 0;
          dv  = $urandom_range(0, 3) == 0;
          hl  = $urandom_range(0, 7) == 0;
        end
        rst = $urandom_range(0, 149) == 0;
        reset = rst;
        set_in(v, rs, rsu, rt, rtu, rd, wen, ld, md, dv, hl);
        model_eval(rst, v, rs, rsu, rt, rtu, md, dv, hl, e_st, e_fa, e_fb, e_start, e_isdiv,
                   e_busy, e_done);
        @(posedge clk);
        chk($sformatf("rnd%0d stall", cyc),  32'(bus.stall), 32'(e_st));
        chk($sformatf("rnd%0d bubble", cyc), 32'(bus.bubble), 32'(e_st));
        chk($sformatf("rnd%0d start", cyc),  32'(bus.muldiv_start), 32'(e_start));
        chk($sformatf("rnd%0d busy", cyc),   32'(bus.muldiv_busy), 32'(e_busy));
        chk($sformatf("rnd%0d done", cyc),   32'(bus.muldiv_done), 32'(e_done));
        if (v) begin
          chk($sformatf("rnd%0d fwd_a", cyc), 32'(bus.fwd_a_sel), 32'(e_fa));
          chk($sformatf("rnd%0d fwd_b", cyc), 32'(bus.fwd_b_sel), 32'(e_fb));
        end
        if (e_start) chk($sformatf("rnd%0d is_div", cyc), 32'(bus.muldiv_is_div), 32'(e_isdiv));
        model_step(rst, v, rd, wen, ld, e_st, e_start, dv);
        prev_st = e_st;
        @(negedge clk); #1;
      end
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
